// File: rtl/data_mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: width codes,
// exception codes and the access state encoding.
package data_mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_access_lane_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads,
// plus legality and alignment classification of a width code.
module ls_lane_align
    import data_mem_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Loads always fetch the full word; lane selection happens on the way back.
    always_comb begin
        wdata   = 32'd0;
        byte_en = 4'b1111;
        if (!is_load) begin
            case (funct3)
                F3_SB: begin
                    wdata   = {4{store_data[7:0]}};
                    byte_en = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    wdata   = {2{store_data[15:0]}};
                    byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                end
                F3_SW: begin
                    wdata   = store_data;
                    byte_en = 4'b1111;
                end
                default: begin
                    wdata   = 32'd0;
                    byte_en = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        if (is_load)
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        else
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});

        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: one req/ack data-memory access per request,
// stalling the pipeline via busy until the single-cycle response.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] load_data,
    output logic [1:0]  exception,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        is_load_q;
    logic [7:0]  wait_cnt;

    logic [1:0]  sel_lane;
    logic [2:0]  sel_funct3;
    logic        sel_is_load;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_byte_en;
    logic [31:0] lane_load_data;
    logic        lane_misaligned;
    logic        lane_illegal;

    // Live request fields are classified at acceptance; the captured ones
    // steer the returning read word while waiting.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_lane    = alu_result[1:0];
            sel_funct3  = funct3;
            sel_is_load = mem_read;
        end else begin
            sel_lane    = lane_q;
            sel_funct3  = funct3_q;
            sel_is_load = is_load_q;
        end
    end

    ls_lane_align u_lane_align (
        .addr_lo    (sel_lane),
        .funct3     (sel_funct3),
        .is_load    (sel_is_load),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .wdata      (lane_wdata),
        .byte_en    (lane_byte_en),
        .load_data  (lane_load_data),
        .misaligned (lane_misaligned),
        .illegal    (lane_illegal)
    );

    assign busy = (state == ST_WAIT) || ((state == ST_IDLE) && (mem_read || mem_write));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            load_data   <= 32'd0;
            exception   <= EXC_NONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_byte_en <= 4'd0;
            wait_cnt    <= 8'd0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            is_load_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (mem_read || mem_write) begin
                        funct3_q  <= funct3;
                        lane_q    <= alu_result[1:0];
                        is_load_q <= mem_read;
                        if (lane_illegal) begin
                            exception <= EXC_ILLEGAL;
                            state     <= ST_RESP;
                        end else if (lane_misaligned) begin
                            exception <= EXC_MISALIGN;
                            state     <= ST_RESP;
                        end else begin
                            mem_req     <= 1'b1;
                            mem_we      <= !mem_read;
                            mem_addr    <= {alu_result[31:2], 2'b00};
                            mem_wdata   <= lane_wdata;
                            mem_byte_en <= lane_byte_en;
                            state       <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        exception <= EXC_NONE;
                        if (is_load_q)
                            load_data <= lane_load_data;
                        state <= ST_RESP;
                    end else if (wait_cnt == 8'(WAIT_LIMIT - 1)) begin
                        mem_req   <= 1'b0;
                        exception <= EXC_TIMEOUT;
                        load_data <= 32'd0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    exception <= EXC_NONE;
                    wait_cnt  <= 8'd0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed vector table, reset and
// stray-ack sequences, then random accesses against a transaction-level model.
module tb_data_mem_access;

    localparam int WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] load_data;
    logic [1:0]  exception;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_ld;

    data_mem_access #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .funct3      (funct3),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .load_data   (load_data),
        .exception   (exception),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_at;
        logic [1:0]  exp_exc;
        logic [31:0] exp_ld;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: result of one access from the ISA rules.
    function automatic void refModel(input logic rd, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] sd,
                                     input logic [31:0] rdata, input int ack_at,
                                     input logic [31:0] prev_ld,
                                     output logic [1:0] exc, output logic [31:0] ld,
                                     output logic [31:0] wdata, output logic [3:0] be);
        int     size;
        int     off;
        longint val;
        longint mask;
        logic   legal;
        size  = 1 << f3[1:0];
        off   = int'(addr % 4);
        legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        ld    = prev_ld;
        wdata = 32'd0;
        be    = 4'hF;
        if (!legal) begin
            exc = 2'b10;
        end else if (off % size != 0) begin
            exc = 2'b01;
        end else if (ack_at == 0) begin
            exc = 2'b11;
            ld  = 32'd0;
        end else begin
            exc = 2'b00;
            if (rd) begin
                mask = (64'd1 << (8 * size)) - 1;
                val  = ({32'd0, rdata} >> (8 * off)) & mask;
                if (!f3[2] && val >= (mask + 1) / 2)
                    val = val - (mask + 1);
                ld = val[31:0];
            end
        end
        if (!rd && legal) begin
            be = 4'(((1 << size) - 1) << off);
            if (size == 1)      wdata = sd[7:0] * 32'h0101_0101;
            else if (size == 2) wdata = sd[15:0] * 32'h0001_0001;
            else                wdata = sd;
        end
    endfunction

    // Drives one request from IDLE, acts as the memory (ack on the ack_at-th
    // request cycle, 0 = never) and checks the whole exchange.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sd, input logic [31:0] rdata,
                                 input int ack_at, input logic [1:0] exp_exc,
                                 input logic [31:0] exp_ld, input logic [31:0] exp_wdata,
                                 input logic [3:0] exp_be);
        int   busy_n = 0;
        int   req_n = 0;
        int   cyc = 0;
        int   exp_busy;
        logic done = 1'b0;
        logic is_store;
        is_store = wr && !rd;
        if (exp_exc == 2'b01 || exp_exc == 2'b10) exp_busy = 1;
        else if (ack_at == 0)                     exp_busy = 1 + WAIT_LIMIT;
        else                                      exp_busy = 1 + ack_at;

        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = addr;
        store_data = sd;
        while (!done && cyc < 300) begin
            #1;
            if (mem_req) begin
                req_n++;
                checkOutput({name, ".addr"}, mem_addr, {addr[31:2], 2'b00});
                checkOutput({name, ".we"}, {31'd0, mem_we}, {31'd0, is_store});
                checkOutput({name, ".be"}, {28'd0, mem_byte_en}, {28'd0, exp_be});
                if (is_store)
                    checkOutput({name, ".wdata"}, mem_wdata, exp_wdata);
                mem_ack   = (req_n == ack_at);
                mem_rdata = mem_ack ? rdata : $urandom;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (!busy) begin
                done = 1'b1;
                checkOutput({name, ".exc"}, {30'd0, exception}, {30'd0, exp_exc});
                checkOutput({name, ".load_data"}, load_data, exp_ld);
                checkOutput({name, ".req_in_resp"}, {31'd0, mem_req}, 32'd0);
            end else begin
                busy_n++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        checkOutput({name, ".resp_seen"}, {31'd0, done}, 32'd1);
        checkOutput({name, ".busy_cycles"}, busy_n, exp_busy);
        checkOutput({name, ".req_cycles"}, req_n, exp_busy - 1);
    endtask

    vec_t vecs[$];

    initial begin
        logic        r_rd;
        logic        r_wr;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [31:0] r_sd;
        logic [31:0] r_rdata;
        int          r_ack;
        logic [1:0]  m_exc;
        logic [31:0] m_ld;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;

        vecs.push_back('{"lb_neg",      1, 0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1, 2'b00, 32'hFFFF_FF80, 32'h0,         4'b1111});
        vecs.push_back('{"sh_hi",       0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         3, 2'b00, 32'hFFFF_FF80, 32'hABCD_ABCD, 4'b1100});
        vecs.push_back('{"lw_misalign", 1, 0, 3'b010, 32'h0000_3001, 32'h0,         32'h0,         1, 2'b01, 32'hFFFF_FF80, 32'h0,         4'b1111});
        vecs.push_back('{"ld_illegal",  1, 0, 3'b011, 32'h0000_3000, 32'h0,         32'h0,         1, 2'b10, 32'hFFFF_FF80, 32'h0,         4'b1111});
        vecs.push_back('{"lw_timeout",  1, 0, 3'b010, 32'h0000_5000, 32'h0,         32'h0,         0, 2'b11, 32'h0000_0000, 32'h0,         4'b1111});
        vecs.push_back('{"lhu_hi",      1, 0, 3'b101, 32'h0000_4002, 32'h0,         32'h9ABC_0000, 1, 2'b00, 32'h0000_9ABC, 32'h0,         4'b1111});
        vecs.push_back('{"lb_pos",      1, 0, 3'b000, 32'h0000_4001, 32'h0,         32'h0000_7F00, 2, 2'b00, 32'h0000_007F, 32'h0,         4'b1111});
        vecs.push_back('{"sb_lane3",    0, 1, 3'b000, 32'h0000_6003, 32'h0000_00A5, 32'h0,         1, 2'b00, 32'h0000_007F, 32'hA5A5_A5A5, 4'b1000});
        vecs.push_back('{"sw",          0, 1, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 32'h0,         2, 2'b00, 32'h0000_007F, 32'hDEAD_BEEF, 4'b1111});
        vecs.push_back('{"st_illegal",  0, 1, 3'b100, 32'h0000_7001, 32'h0,         32'h0,         1, 2'b10, 32'h0000_007F, 32'h0,         4'b1111});
        vecs.push_back('{"lh_misalign", 1, 0, 3'b001, 32'h0000_8001, 32'h0,         32'h0,         1, 2'b01, 32'h0000_007F, 32'h0,         4'b1111});
        vecs.push_back('{"lh_neg",      1, 0, 3'b001, 32'h0000_8002, 32'h0,         32'h8001_0000, 1, 2'b00, 32'hFFFF_8001, 32'h0,         4'b1111});
        vecs.push_back('{"rd_wins",     1, 1, 3'b100, 32'h0000_9000, 32'h0,         32'h0000_00F0, 1, 2'b00, 32'h0000_00F0, 32'h0,         4'b1111});
        vecs.push_back('{"sh_misalign", 0, 1, 3'b001, 32'h0000_2001, 32'h0,         32'h0,         1, 2'b01, 32'h0000_00F0, 32'h0,         4'b1111});
        vecs.push_back('{"sw_timeout",  0, 1, 3'b010, 32'h0000_A000, 32'h5555_AAAA, 32'h0,         0, 2'b11, 32'h0000_0000, 32'h5555_AAAA, 4'b1111});

        reset      = 1'b1;
        alu_result = 32'd0;
        store_data = 32'd0;
        funct3     = 3'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst.load_data", load_data, 32'd0);
        checkOutput("rst.exception", {30'd0, exception}, 32'd0);
        checkOutput("rst.req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst.we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst.addr", mem_addr, 32'd0);
        checkOutput("rst.wdata", mem_wdata, 32'd0);
        checkOutput("rst.be", {28'd0, mem_byte_en}, 32'd0);
        checkOutput("rst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Table entries run back to back, so each held request crosses RESP.
        foreach (vecs[i])
            applyStimulus(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                          vecs[i].sdata, vecs[i].rdata, vecs[i].ack_at, vecs[i].exp_exc,
                          vecs[i].exp_ld, vecs[i].exp_wdata, vecs[i].exp_be);

        // Stray ack while idle must not touch load_data.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("idle_ack.load_data", load_data, 32'd0);
        checkOutput("idle_ack.busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_ack.req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        // Reset in the second WAIT cycle, ack arriving one cycle late.
        applyStimulus("pre_rst_lw", 1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 1,
                      2'b00, 32'h1234_5678, 32'h0, 4'b1111);
        mem_read   = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_0200;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("mid_rst.req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("mid_rst.req", {31'd0, mem_req}, 32'd0);
        checkOutput("mid_rst.load_data", load_data, 32'd0);
        checkOutput("mid_rst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("late_ack.load_data", load_data, 32'd0);
        checkOutput("late_ack.exception", {30'd0, exception}, 32'd0);
        checkOutput("late_ack.req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        model_ld = 32'd0;
        for (int n = 0; n < 40; n++) begin
            r_rd    = 1'($urandom % 2);
            r_wr    = r_rd ? 1'($urandom % 2) : 1'b1;
            r_f3    = 3'($urandom % 8);
            r_addr  = $urandom;
            r_sd    = $urandom;
            r_rdata = $urandom;
            r_ack   = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 4));
            refModel(r_rd, r_f3, r_addr, r_sd, r_rdata, r_ack, model_ld,
                     m_exc, m_ld, m_wdata, m_be);
            applyStimulus($sformatf("rand%0d", n), r_rd, r_wr, r_f3, r_addr, r_sd, r_rdata,
                          r_ack, m_exc, m_ld, m_wdata, m_be);
            model_ld = m_ld;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- MEM-stage block of the RV32IM pipeline, directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3 from the EX/MEM register.
- Runs one load or store per request over a req/ack data-memory port, performing byte-lane steering and load sign/zero extension.
- Raises BUSY to stall the pipeline while an access is outstanding, and reports misalignment, illegal funct3 and bus timeout.

Parameters:
WAIT_LIMIT, 15, max cycles in WAIT without MEM_ACK before a timeout exception (1..255)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
ALU_RESULT  input  32  effective address from the ALU
STORE_DATA  input  32  rs2 value for stores
FUNCT3  input  3  RV32I load/store width code
MEM_READ  input  1  load request, held until BUSY low
MEM_WRITE  input  1  store request, held until BUSY low
LOAD_DATA  output  32  extended load result, valid in RESP, held afterwards
EXCEPTION  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid in RESP only
BUSY  output  1  pipeline stall request
MEM_REQ  output  1  memory request
MEM_WE  output  1  1 = write
MEM_ADDR  output  32  word address: {ALU_RESULT[31:2],2'b00}
MEM_WDATA  output  32  lane-replicated store data
MEM_BYTE_EN  output  4  byte enables
MEM_RDATA  input  32  memory read word
MEM_ACK  input  1  memory completes the request in this cycle

Behaviour:
- States are IDLE, WAIT and RESP.
- Reset values: state IDLE, LOAD_DATA 0, EXCEPTION 00, MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, MEM_BYTE_EN 0, wait counter 0.
- Acceptance, in IDLE with MEM_READ or MEM_WRITE high:
  - If both are high, the read wins.
  - BUSY goes high combinationally in that same cycle.
  - Address, width, data and direction are registered.
- Legal FUNCT3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For stores: 000, 001, 010. Anything else is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Illegal or misaligned request: IDLE->RESP, MEM_REQ is never raised, EXCEPTION = 10 or 01 in RESP, LOAD_DATA unchanged. Illegal funct3 takes priority over misaligned.
- Legal request: IDLE->WAIT.
  - In WAIT, MEM_REQ=1, and MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN are stable.
  - BUSY=1.
  - The counter increments each WAIT cycle.
- MEM_ACK is sampled only in WAIT; an ack in any other state is ignored.
  - Ack on a load: LOAD_DATA is registered from MEM_RDATA, and the next state is RESP with EXCEPTION 00.
  - Ack on a store: next state RESP.
  - MEM_REQ drops on entry to RESP.
- Timeout: the counter reaches WAIT_LIMIT with no ack -> RESP, EXCEPTION 11, LOAD_DATA 0.
- RESP lasts exactly 1 cycle with BUSY=0.
  - The pipeline advances at the end of RESP; request inputs are ignored in RESP.
  - Next state IDLE; EXCEPTION returns to 00.
- Minimum latency for a legal access: 3 cycles (accept, WAIT with ack, RESP), with BUSY high for 2.
- Load extraction uses lane = addr[1:0]:
  - LB/LBU: byte[lane], sign- or zero-extended.
  - LH/LHU: half[addr[1]], sign- or zero-extended.
  - LW: whole word.
- Store steering:
  - SB: byte replicated x4, BYTE_EN = 0001<<addr[1:0].
  - SH: half replicated x2, BYTE_EN = 0011<<{addr[1],1'b0}.
  - SW: data unchanged, BYTE_EN 1111.
- MEM_BYTE_EN is 1111 on loads; read-data lane selection happens internally.
- RESET mid-access: the state returns to IDLE at that edge, MEM_REQ drops and LOAD_DATA clears. A late ack is ignored.

Decomposition:
- Shared package holds:
  - FUNCT3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - EXCEPTION codes.
  - State encoding.
- One combinational sub-module, ls_lane_align, takes addr[1:0], funct3, store data and read word, and returns MEM_WDATA, MEM_BYTE_EN, extended load data, misaligned flag and illegal flag.

Test Plan:
- LB at addr 0x1003, MEM_RDATA=0x80FF_1234, ack in 1st WAIT cycle -> LOAD_DATA=0xFFFF_FF80, EXCEPTION 00, BUSY high for 2 cycles, MEM_ADDR=0x1000.
- SH at 0x2002, STORE_DATA=0x1234_ABCD -> MEM_WDATA=0xABCD_ABCD, MEM_BYTE_EN=1100, MEM_WE=1, MEM_REQ held until ack after 3 wait cycles.
- LW at 0x3001 -> no MEM_REQ, RESP next cycle with EXCEPTION 01. FUNCT3=011 load -> EXCEPTION 10.
- Load with MEM_ACK never asserted, WAIT_LIMIT=15 -> EXCEPTION 11 after 15 WAIT cycles, LOAD_DATA=0, MEM_REQ low in RESP.
- LHU at 0x4002, MEM_RDATA=0x9ABC_0000 -> LOAD_DATA=0x0000_9ABC. Back-to-back requests held across RESP produce exactly one access each.
- RESET asserted in 2nd WAIT cycle, ack arrives next cycle -> state IDLE, MEM_REQ 0, LOAD_DATA 0, ack ignored.
